// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Covers the picker, the top level and the optional bus-lock build (MEM_ARB_LOCK_EN).
package mem_arb_pkg;

  localparam int MAX_REQ = 4;

  typedef logic [1:0] req_id_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational picker: scans req_i starting at start_i (wrapping modulo N)
// and returns the first requester found as a one-hot grant plus its index.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   start_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o,
  output logic [1:0]   id_o
);

  // NOTE: every output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    logic found;
    found   = 1'b0;
    gnt_o   = '0;
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req_i[j] && (j == (int'(start_i) + k) % N)) begin
          found    = 1'b1;
          valid_o  = 1'b1;
          gnt_o[j] = 1'b1;
          id_o     = req_id_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N_REQ-way arbiter sharing one single-cycle-latency memory port.
// Define MEM_ARB_LOCK_EN to enable the bus-lock (lock_i) feature.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter bit RR_EN_DEFAULT = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*4-1:0]  wstrb_i,
  input  logic [N_REQ*32-1:0] addr_i,
  input  logic [N_REQ*32-1:0] wdata_i,
  input  logic [N_REQ-1:0]    lock_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                enable_o,
  output logic [3:0]          wstrb_o,
  output logic [31:0]         addr_o,
  output logic [31:0]         wvalue_o,
  input  logic [31:0]         rvalue_i
);

  req_id_t          last_q, last_d;
  req_id_t          rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  req_id_t          start_idx, pick_id;
  logic             pick_valid, pick_read;
  logic [N_REQ-1:0] req_eff, pick_gnt;

`ifdef MEM_ARB_LOCK_EN
  logic             lock_owner_valid_q, lock_owner_valid_d;
  req_id_t          lock_owner_q, lock_owner_d;
  logic [N_REQ-1:0] owner_mask;
  logic             lock_active;

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_mask[i] = (lock_owner_q == req_id_t'(i));
    end
  end

  // The lock survives an idle owner only while it keeps lock_i asserted.
  assign lock_active = lock_owner_valid_q && |((req_i | lock_i) & owner_mask);
  assign req_eff     = lock_active ? (req_i & owner_mask) : req_i;

  always_comb begin
    lock_owner_valid_d = lock_active;
    lock_owner_d       = lock_owner_q;
    if (pick_valid) begin
      lock_owner_valid_d = |(pick_gnt & lock_i);
      lock_owner_d       = pick_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_owner_valid_q <= 1'b0;
      lock_owner_q       <= '0;
    end else begin
      lock_owner_valid_q <= lock_owner_valid_d;
      lock_owner_q       <= lock_owner_d;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^lock_i;
  assign req_eff     = req_i;
`endif

  always_comb begin
    start_idx = '0;
    if (RR_EN_DEFAULT) begin
      start_idx = (last_q == req_id_t'(N_REQ - 1)) ? '0 : last_q + 2'd1;
    end
  end

  mem_arb_pick #(
    .N (N_REQ)
  ) u_pick (
    .req_i   (req_eff),
    .start_i (start_idx),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_comb begin
    gnt_o    = '0;
    enable_o = 1'b0;
    wstrb_o  = STRB_NONE;
    addr_o   = '0;
    wvalue_o = '0;
    if (!rst_i && pick_valid) begin
      gnt_o    = pick_gnt;
      enable_o = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (pick_gnt[i]) begin
          wstrb_o  = wstrb_i[i*4 +: 4];
          addr_o   = addr_i[i*32 +: 32];
          wvalue_o = wdata_i[i*32 +: 32];
        end
      end
    end
  end

  assign pick_read = pick_valid && (wstrb_o == STRB_NONE);

  always_comb begin
    last_d      = pick_valid ? pick_id : last_q;
    rsp_valid_d = pick_read;
    rsp_id_d    = pick_read ? pick_id : rsp_id_q;
  end

  // A response still in flight when reset hits is suppressed, not delivered late.
  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid_o[i] = rsp_valid_q && !rst_i && (rsp_id_q == req_id_t'(i));
    end
  end

  assign rdata_o = rvalue_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= req_id_t'(N_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority instances,
// a read-response scoreboard, and the lock feature when MEM_ARB_LOCK_EN is set.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [31:0] rvalue;
  logic [3:0]  strb_t  [2];
  logic [31:0] addr_t  [2];
  logic [31:0] wdata_t [2];
  logic [7:0]  wstrb_bus;
  logic [63:0] addr_bus, wdata_bus;

  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, addr_o, wvalue_o;
  logic [3:0]  wstrb_o;
  logic        enable;

  logic [1:0]  fp_gnt;
  logic        fp_enable;
  logic [1:0]  fp_rvalid_unused;
  logic [31:0] fp_rdata_unused, fp_addr_unused, fp_wvalue_unused;
  logic [3:0]  fp_wstrb_unused;

  int checks = 0;
  int errors = 0;
  rsp_t rsp_q[$];
  logic [31:0] next_rvalue = 32'h0;

  assign wstrb_bus = {strb_t[1], strb_t[0]};
  assign addr_bus  = {addr_t[1], addr_t[0]};
  assign wdata_bus = {wdata_t[1], wdata_t[0]};

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(2), .RR_EN_DEFAULT(1'b1)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .wstrb_i  (wstrb_bus),
    .addr_i   (addr_bus),
    .wdata_i  (wdata_bus),
    .lock_i   (lock),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .enable_o (enable),
    .wstrb_o  (wstrb_o),
    .addr_o   (addr_o),
    .wvalue_o (wvalue_o),
    .rvalue_i (rvalue)
  );

  mem_arbiter #(.N_REQ(2), .RR_EN_DEFAULT(1'b0)) dut_fp (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .wstrb_i  (wstrb_bus),
    .addr_i   (addr_bus),
    .wdata_i  (wdata_bus),
    .lock_i   (lock),
    .gnt_o    (fp_gnt),
    .rvalid_o (fp_rvalid_unused),
    .rdata_o  (fp_rdata_unused),
    .enable_o (fp_enable),
    .wstrb_o  (fp_wstrb_unused),
    .addr_o   (fp_addr_unused),
    .wvalue_o (fp_wvalue_unused),
    .rvalue_i (rvalue)
  );

  // Memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                      input logic [1:0] exp_gnt);
    logic [1:0] exp_fp;
    logic [1:0] exp_rv;
    logic [31:0] exp_rd;
    rsp_t e;
    int id;
    rst    = r;
    req    = rq;
    lock   = lk;
    rvalue = next_rvalue;
    exp_fp = r ? 2'b00 : (rq[0] ? 2'b01 : (rq[1] ? 2'b10 : 2'b00));
    if (r) rsp_q.delete();
    @(negedge clk);
    exp_rv = 2'b00;
    exp_rd = rvalue;
    if (rsp_q.size() > 0) begin
      e      = rsp_q.pop_front();
      exp_rv = (e.id == 2'd1) ? 2'b10 : 2'b01;
      exp_rd = e.data;
    end
    check("rvalid", 32'(rvalid), 32'(exp_rv));
    check("rdata", rdata, exp_rd);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("enable", 32'(enable), 32'(|exp_gnt));
    check("fp_gnt", 32'(fp_gnt), 32'(exp_fp));
    check("fp_enable", 32'(fp_enable), 32'(|exp_fp));
    if (exp_gnt != 2'b00) begin
      id = exp_gnt[1] ? 1 : 0;
      check("wstrb_o", 32'(wstrb_o), 32'(strb_t[id]));
      check("addr_o", addr_o, addr_t[id]);
      check("wvalue_o", wvalue_o, wdata_t[id]);
      if (strb_t[id] == STRB_NONE) rsp_q.push_back('{id: 2'(id), data: mem_f(addr_t[id])});
    end else begin
      check("idle_wstrb", 32'(wstrb_o), 32'h0);
      check("idle_addr", addr_o, 32'h0);
      check("idle_wvalue", wvalue_o, 32'h0);
    end
    next_rvalue = (enable && wstrb_o == STRB_NONE) ? mem_f(addr_o) : $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    strb_t[0]  = STRB_NONE;     strb_t[1]  = STRB_NONE;
    addr_t[0]  = 32'h0000_0040; addr_t[1]  = 32'h0000_0084;
    wdata_t[0] = 32'h1111_2222; wdata_t[1] = 32'h3333_4444;

    // Reset holds every output low even with requests pending.
    step(1'b1, 2'b11, 2'b00, 2'b00);
    step(1'b1, 2'b11, 2'b00, 2'b00);

    // Round-robin alternation on continuous reads; fixed priority starves requester 1.
    step(1'b0, 2'b11, 2'b00, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b10);
    step(1'b0, 2'b00, 2'b00, 2'b00);

    // Half-word write from requester 1: no read response follows.
    strb_t[1]  = STRB_H;
    addr_t[1]  = 32'h0000_0100;
    wdata_t[1] = 32'h0000_BEEF;
    step(1'b0, 2'b10, 2'b00, 2'b10);
    step(1'b0, 2'b00, 2'b00, 2'b00);

    // Requester 1 drops its request before being served, then returns.
    step(1'b0, 2'b11, 2'b00, 2'b01);
    step(1'b0, 2'b01, 2'b00, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b01);

    // Read grant to requester 0, then reset: the response is dropped.
    strb_t[1] = STRB_NONE;
    step(1'b0, 2'b01, 2'b00, 2'b01);
    step(1'b1, 2'b11, 2'b00, 2'b00);
    check("last_q_after_reset", 32'(dut.last_q), 32'd1);
    step(1'b0, 2'b11, 2'b00, 2'b01);

`ifdef MEM_ARB_LOCK_EN
    // Requester 1 locks the bus for three grants, then releases it.
    step(1'b0, 2'b11, 2'b10, 2'b10);
    step(1'b0, 2'b11, 2'b10, 2'b10);
    step(1'b0, 2'b11, 2'b10, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b01);
`else
    // Without the lock feature lock_i has no effect on alternation.
    step(1'b0, 2'b11, 2'b10, 2'b10);
    step(1'b0, 2'b11, 2'b10, 2'b01);
    step(1'b0, 2'b11, 2'b10, 2'b10);
    step(1'b0, 2'b11, 2'b00, 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b10);
`endif
    step(1'b0, 2'b00, 2'b00, 2'b00);
    check("scoreboard_empty", 32'(rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters sharing the single memory port (legal 2..4).
REQ-002 Parameter RR_EN_DEFAULT, default 1; 1 = round-robin arbitration, 0 = fixed priority with lowest index highest.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 req_i  input  N_REQ  per-requester access request, held until granted.
REQ-006 wstrb_i  input  N_REQ*4  per-requester byte strobes; all zero = read.
REQ-007 addr_i  input  N_REQ*32  per-requester byte address.
REQ-008 wdata_i  input  N_REQ*32  per-requester write data.
REQ-009 lock_i  input  N_REQ  per-requester bus-lock hold (only with MEM_ARB_LOCK_EN).
REQ-010 gnt_o  output  N_REQ  one-hot; request accepted and driven to memory this cycle.
REQ-011 rvalid_o  output  N_REQ  one-hot; read data for that requester's previous-cycle read is on rdata_o.
REQ-012 rdata_o  output  32  memory read data, broadcast to all requesters.
REQ-013 enable_o, wstrb_o[3:0], addr_o[31:0], wvalue_o[31:0]  output  memory port, same semantics as the CPU memory port.
REQ-014 rvalue_i  input  32  memory read data, valid exactly one cycle after an enable_o read.

Function
REQ-015 Arbitration is combinational each cycle: winner chosen from req_i; its wstrb/addr/wdata drive the memory port; gnt_o[winner]=1, enable_o=1.
REQ-016 No request pending: enable_o=0, gnt_o=0, wstrb_o=0, addr_o=0, wvalue_o=0.
REQ-017 Round-robin: register last_q holds the index of the last grant; search starts at last_q+1 modulo N_REQ; last_q updates only on a grant.
REQ-018 Fixed priority (RR_EN_DEFAULT=0): lowest set req_i index wins; last_q still tracked but unused.
REQ-019 One grant per cycle, back-to-back grants allowed (pipelined); throughput one access per cycle.
REQ-020 Read response: granted read sets rsp_valid_q=1, rsp_id_q=winner; next cycle rvalid_o[rsp_id_q]=1, rdata_o=rvalue_i.
REQ-021 Writes (wstrb nonzero) produce no rvalid_o pulse; read latency fixed at 1 cycle after gnt_o.
REQ-022 Grant and response to different (or same) requesters in the same cycle are independent and both legal.
REQ-023 A requester dropping req_i before grant is legal; no state change results.
REQ-024 rdata_o=rvalue_i always; only rvalid_o qualifies it.

Reset
REQ-025 While rst_i=1: gnt_o=0, rvalid_o=0, enable_o=0, wstrb_o=0 regardless of req_i.
REQ-026 Reset values: last_q=N_REQ-1 (requester 0 first after reset), rsp_valid_q=0, rsp_id_q=0, lock_owner_valid_q=0.
REQ-027 Reset asserted the cycle after a read grant: the pending rvalid_o is dropped, not delivered.

Configuration
REQ-028 Macro MEM_ARB_LOCK_EN defined: requester granted with lock_i=1 becomes lock owner; only its requests are granted until a cycle where it is granted with lock_i=0 or it drops req_i with lock_i=0; others wait.
REQ-029 MEM_ARB_LOCK_EN undefined: lock_i ignored, no lock-owner state exists, arbitration per REQ-017/018 only.

Structure
REQ-030 Package mem_arb_pkg holds MAX_REQ=4, typedef req_id_t (2-bit), and strobe constants STRB_NONE/STRB_B/STRB_H/STRB_W.
REQ-031 One sub-module mem_arb_pick: combinational priority/round-robin picker (req vector, start index -> one-hot winner, valid).

Verification
REQ-032 req_i=2'b11 held 4 cycles, RR, both reads -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later with matching rdata_o.
REQ-033 Fixed priority, req_i=2'b11 for 3 cycles -> gnt_o=01 every cycle; requester 1 starved.
REQ-034 Req 1 write wstrb=4'b0011 addr=0x100 wdata=0xBEEF -> enable_o=1, wstrb_o=0011, addr_o=0x100, wvalue_o=0xBEEF same cycle; no rvalid_o next cycle.
REQ-035 Read grant to req 0 then rst_i=1 next cycle -> rvalid_o=0, last_q=1 afterwards; first post-reset grant with req_i=11 goes to requester 0.
REQ-036 MEM_ARB_LOCK_EN, req 1 granted with lock_i[1]=1 while req_i=11 for 3 cycles -> gnt_o=10 each cycle; lock_i[1]=0 on next grant releases, following grant 01.
